// File: rtl/msg_sched_stream.sv
// SHA-256/SHA-512 message-schedule generator: loads a 16-word block, then streams W[0..ROUNDS-1].
// Define MSG_SCHED_IDX_OUT_EN to expose the current round index on T_IDX.
module msg_sched_stream #(
   parameter int WORD_W = 32,
   parameter int ROUNDS = 64
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              IN_VALID,
   output logic              IN_READY,
   input  logic [WORD_W-1:0] D_IN,
   output logic              OUT_VALID,
   input  logic              OUT_READY,
   output logic [WORD_W-1:0] D_OUT,
`ifdef MSG_SCHED_IDX_OUT_EN
   output logic [6:0]        T_IDX,
`endif
   output logic              DONE
);

   if (WORD_W != 32 && WORD_W != 64) begin : g_bad_word_w
      $error("msg_sched_stream: WORD_W must be 32 or 64");
   end
   if (ROUNDS < 16 || ROUNDS > 127) begin : g_bad_rounds
      $error("msg_sched_stream: ROUNDS must be in 16..127");
   end

   localparam bit   W64    = (WORD_W == 64);
   localparam int   S0_RA  = W64 ? 1  : 7;
   localparam int   S0_RB  = W64 ? 8  : 18;
   localparam int   S0_SH  = W64 ? 7  : 3;
   localparam int   S1_RA  = W64 ? 19 : 17;
   localparam int   S1_RB  = W64 ? 61 : 19;
   localparam int   S1_SH  = W64 ? 6  : 10;
   localparam logic [6:0] T_LAST = 7'(ROUNDS - 1);

   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

   state_t                   state, state_nxt;
   logic [3:0]               k, k_nxt;
   logic [6:0]               t, t_nxt;
   logic [15:0][WORD_W-1:0]  w;
   logic                     in_hs, out_hs, last;
   logic [WORD_W-1:0]        next_w;

   function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
      return (x >> n) | (x << (WORD_W - n));
   endfunction

   function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
      return rotr(x, S0_RA) ^ rotr(x, S0_RB) ^ (x >> S0_SH);
   endfunction

   function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
      return rotr(x, S1_RA) ^ rotr(x, S1_RB) ^ (x >> S1_SH);
   endfunction

   // Registers only: keeps D_IN/OUT_READY off the D_OUT timing path.
   assign next_w = sig1(w[14]) + w[9] + sig0(w[1]) + w[0];

   always_comb begin
      state_nxt = state;
      k_nxt     = k;
      t_nxt     = t;
      in_hs     = 1'b0;
      out_hs    = 1'b0;
      last      = 1'b0;
      IN_READY  = 1'b0;
      OUT_VALID = 1'b0;
      case (state)
         IDLE, LOAD: begin
            IN_READY = 1'b1;
            if (IN_VALID) begin
               in_hs = 1'b1;
               k_nxt = k + 4'd1;
               if (k == 4'd15) begin
                  state_nxt = RUN;
                  t_nxt     = 7'd0;
               end else begin
                  state_nxt = LOAD;
               end
            end
         end
         RUN: begin
            OUT_VALID = 1'b1;
            if (OUT_READY) begin
               out_hs = 1'b1;
               if (t == T_LAST) begin
                  state_nxt = IDLE;
                  t_nxt     = 7'd0;
                  last      = 1'b1;
               end else begin
                  t_nxt = t + 7'd1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
         k     <= '0;
         t     <= '0;
         w     <= '0;
         DONE  <= 1'b0;
      end else begin
         state <= state_nxt;
         k     <= k_nxt;
         t     <= t_nxt;
         DONE  <= last;
         if (in_hs)
            w[k] <= D_IN;
         else if (out_hs)
            w <= {next_w, w[15:1]};
      end
   end

   assign D_OUT = w[0];

`ifdef MSG_SCHED_IDX_OUT_EN
   assign T_IDX = OUT_VALID ? t : 7'd0;
`endif

endmodule

// File: tb/tb_msg_sched_stream.sv
// Bench for msg_sched_stream: SHA-256 and SHA-512 instances checked against a textbook schedule model.
module tb_msg_sched_stream;

   logic        clk = 1'b0;
   logic        rst, in_valid, out_ready, sel;
   logic [63:0] d_in;

   logic        ir32, ov32, dn32, ir64, ov64, dn64;
   logic [31:0] do32;
   logic [63:0] do64;
   logic [63:0] in_rdy, o_vld, o_done, o_data;
   logic [63:0] exp_w [128];
   logic [63:0] cap   [128];
   logic [63:0] msg   [16];
   int          n_cmp = 0, n_err = 0;

   always #5 clk = ~clk;

`ifdef MSG_SCHED_IDX_OUT_EN
   logic [6:0]  ti32, ti64;
   logic [63:0] o_tidx;
   assign o_tidx = 64'(sel ? ti64 : ti32);
`endif

   msg_sched_stream #(.WORD_W(32), .ROUNDS(64)) dut32 (
      .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(ir32), .D_IN(d_in[31:0]),
      .OUT_VALID(ov32), .OUT_READY(out_ready), .D_OUT(do32),
`ifdef MSG_SCHED_IDX_OUT_EN
      .T_IDX(ti32),
`endif
      .DONE(dn32));

   msg_sched_stream #(.WORD_W(64), .ROUNDS(80)) dut64 (
      .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(ir64), .D_IN(d_in),
      .OUT_VALID(ov64), .OUT_READY(out_ready), .D_OUT(do64),
`ifdef MSG_SCHED_IDX_OUT_EN
      .T_IDX(ti64),
`endif
      .DONE(dn64));

   assign in_rdy = 64'(sel ? ir64 : ir32);
   assign o_vld  = 64'(sel ? ov64 : ov32);
   assign o_done = 64'(sel ? dn64 : dn32);
   assign o_data = sel ? do64 : {32'h0, do32};

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Reference schedule straight from the SHA-2 recurrence.
   function automatic logic [63:0] ror(input logic [63:0] x, input int n, input bit w64);
      logic [31:0] y;
      y = x[31:0];
      if (w64) return (x >> n) | (x << (64 - n));
      return {32'h0, (y >> n) | (y << (32 - n))};
   endfunction

   function automatic logic [63:0] s0(input logic [63:0] x, input bit w64);
      return w64 ? ror(x, 1, 1) ^ ror(x, 8, 1) ^ (x >> 7)
                 : ror(x, 7, 0) ^ ror(x, 18, 0) ^ (x >> 3);
   endfunction

   function automatic logic [63:0] s1(input logic [63:0] x, input bit w64);
      return w64 ? ror(x, 19, 1) ^ ror(x, 61, 1) ^ (x >> 6)
                 : ror(x, 17, 0) ^ ror(x, 19, 0) ^ (x >> 10);
   endfunction

   task automatic build_model(input bit w64, input int rounds);
      logic [63:0] s;
      for (int i = 0; i < rounds; i++) begin
         if (i < 16) s = msg[i];
         else s = s1(exp_w[i-2], w64) + exp_w[i-7] + s0(exp_w[i-15], w64) + exp_w[i-16];
         if (!w64) s[63:32] = 32'h0;
         exp_w[i] = s;
      end
   endtask

   task automatic abc_msg();
      for (int i = 0; i < 16; i++) msg[i] = 64'h0;
      msg[0]  = 64'h61626380;
      msg[15] = 64'h18;
   endtask

   task automatic rand_msg(input bit w64);
      for (int i = 0; i < 16; i++)
         msg[i] = w64 ? {$urandom, $urandom} : {32'h0, $urandom};
   endtask

   task automatic load_blk(input int gap_pct, input bit b2b);
      int k = 0, cyc = 0, gap;
      while (k < 16 && cyc < 1000) begin
         if (!(b2b && cyc == 0)) begin
            @(negedge clk);
            chk("load_out_valid", o_vld, 64'd0);
            chk("load_done", o_done, 64'd0);
         end
         gap = (b2b && cyc == 0) ? 0 : gap_pct;
         cyc++;
         if (int'($urandom_range(99)) < gap) begin
            in_valid = 1'b0;
            d_in     = {$urandom, $urandom};
         end else begin
            in_valid = 1'b1;
            d_in     = msg[k];
            chk("load_in_ready", in_rdy, 64'd1);
            if (in_rdy[0]) k++;
         end
      end
      if (k < 16) chk("load_timeout", 64'(k), 64'd16);
   endtask

   task automatic run_blk(input int stop_t, input int bp_pct, input bit hold_iv);
      int t = 0, cyc = 0;
      while (t < stop_t && cyc < 5000) begin
         @(negedge clk);
         cyc++;
         chk("run_out_valid", o_vld, 64'd1);
         chk("run_in_ready", in_rdy, 64'd0);
         chk("run_done", o_done, 64'd0);
         chk($sformatf("W%0d", t), o_data, exp_w[t]);
`ifdef MSG_SCHED_IDX_OUT_EN
         chk("t_idx", o_tidx, 64'(t));
`endif
         in_valid  = hold_iv;
         d_in      = {$urandom, $urandom};
         out_ready = (int'($urandom_range(99)) >= bp_pct);
         if (out_ready) begin
            cap[t] = o_data;
            t++;
         end
      end
      if (t < stop_t) chk("run_timeout", 64'(t), 64'(stop_t));
   endtask

   task automatic chk_done(input string tag);
      @(negedge clk);
      chk({tag, "_done"}, o_done, 64'd1);
      chk({tag, "_idle_valid"}, o_vld, 64'd0);
      chk({tag, "_idle_ready"}, in_rdy, 64'd1);
      in_valid  = 1'b0;
      out_ready = 1'b0;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_in_ready"}, in_rdy, 64'd1);
      chk({tag, "_out_valid"}, o_vld, 64'd0);
      chk({tag, "_d_out"}, o_data, 64'd0);
      chk({tag, "_done"}, o_done, 64'd0);
`ifdef MSG_SCHED_IDX_OUT_EN
      chk({tag, "_t_idx"}, o_tidx, 64'd0);
`endif
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; d_in = '0; sel = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset("rst256");
      rst = 1'b0;

      // "abc" block, no backpressure
      abc_msg(); build_model(0, 64);
      load_blk(0, 0); run_blk(64, 0, 0); chk_done("abc");
      chk("abc_W16", cap[16], 64'h61626380);
      chk("abc_W17", cap[17], 64'h000F0000);
      chk("abc_W63", cap[63], 64'h12B1EDEB);

      // output backpressure
      load_blk(0, 0); run_blk(64, 50, 0); chk_done("bp");
      chk("bp_W63", cap[63], 64'h12B1EDEB);

      // input gaps, IN_VALID held high through RUN
      load_blk(40, 0); run_blk(64, 30, 1); chk_done("gap");
      chk("gap_W63", cap[63], 64'h12B1EDEB);

      // reset mid-RUN at t=30, then reload
      load_blk(0, 0); run_blk(30, 0, 0);
      @(negedge clk);
      chk("pre_rst_W30", o_data, exp_w[30]);
      rst = 1'b1; out_ready = 1'b1; in_valid = 1'b0;
      @(negedge clk);
      chk_reset("midrun");
      rst = 1'b0;
      @(negedge clk);
      chk("midrun_no_done", o_done, 64'd0);
      load_blk(0, 0); run_blk(64, 20, 0); chk_done("reload");
      chk("reload_W63", cap[63], 64'h12B1EDEB);

      // random blocks, back-to-back loading in the DONE cycle
      rand_msg(0); build_model(0, 64);
      load_blk(20, 0); run_blk(64, 30, 0); chk_done("r0");
      for (int b = 1; b < 4; b++) begin
         rand_msg(0); build_model(0, 64);
         load_blk(20, 1); run_blk(64, 30, b[0]);
         chk_done($sformatf("r%0d", b));
      end

      // SHA-512
      rst = 1'b1; sel = 1'b1;
      @(negedge clk);
      chk_reset("rst512");
      rst = 1'b0;
      for (int i = 0; i < 16; i++) msg[i] = 64'h0;
      msg[0] = 64'h1;
      build_model(1, 80);
      load_blk(0, 0); run_blk(80, 0, 0); chk_done("s512");
      chk("s512_W16", cap[16], 64'h1);
      chk("s512_W17", cap[17], 64'h0);
      rand_msg(1); build_model(1, 80);
      load_blk(30, 1); run_blk(80, 40, 1); chk_done("s512r");
      @(negedge clk);
      chk("s512r_done_pulse", o_done, 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/msg_sched_stream.md
Name: msg_sched_stream

Overview:
- Parametrised SHA-2 message-schedule generator for SHA-256 (32-bit words) and SHA-512 (64-bit words).
- Accepts one 16-word message block over a valid/ready input stream.
- Emits the full round sequence W[0..ROUNDS-1] over a valid/ready output stream.
- Sits between block padding/load logic and the compression round datapath. Holds a 16-word sliding window internally.

Parameters:
- WORD_W, 32: word width. Legal values are 32 (SHA-256 sigma set) and 64 (SHA-512 sigma set); any other value is an elaboration error.
- ROUNDS, 64: number of schedule words emitted per block. Must be >= 16 and <= 127. Use 80 for SHA-512.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- IN_VALID  in  1  message word D_IN valid.
- IN_READY  out  1  block can accept a message word.
- D_IN  in  WORD_W  message word M[k], k = 0..15, big-endian word order.
- OUT_VALID  out  1  D_OUT holds W[t].
- OUT_READY  in  1  consumer accepts W[t].
- D_OUT  out  WORD_W  schedule word W[t]; driven directly from window register w[0].
- DONE  out  1  one-cycle pulse on the cycle after W[ROUNDS-1] is accepted.

Behaviour:
- Reset (RST=1 at a CLK edge) takes priority over all other activity.
  - Clears state to IDLE, load count k=0, round count t=0, all window words w[0..15]=0, DONE=0.
  - Outputs after reset: IN_READY=1, OUT_VALID=0, D_OUT=0.
  - Reset mid-LOAD or mid-RUN discards the block; no DONE is issued.
- State IDLE/LOAD: IN_READY=1, OUT_VALID=0.
  - An input handshake (IN_VALID & IN_READY) writes w[k]<=D_IN and increments k.
  - The first accepted word moves the state from IDLE to LOAD.
  - Accepting word k=15 moves the state to RUN on the same edge, with t=0 and k=0.
  - IN_VALID=0 stalls indefinitely with no state change.
- State RUN: IN_READY=0 (words offered on the input are not accepted), OUT_VALID=1, D_OUT=w[0]=W[t].
  - Latency: W[0] is visible on the cycle after M15 is accepted.
  - On an output handshake (OUT_VALID & OUT_READY): w[i]<=w[i+1] for i=0..14, w[15]<=NEXT, t<=t+1.
  - NEXT = sigma1(w[14]) + w[9] + sigma0(w[1]) + w[0], computed modulo 2^WORD_W; carries are discarded.
  - OUT_READY=0 holds D_OUT and all state stable.
  - The handshake that accepts t=ROUNDS-1 returns the state to IDLE with t=0. DONE=1 on the following cycle only.
  - Because IN_READY=1 again in IDLE, a new block may begin loading in the same cycle that DONE is high.
- Sigma functions for WORD_W=32:
  - sigma0 = ROTR7 ^ ROTR18 ^ SHR3
  - sigma1 = ROTR17 ^ ROTR19 ^ SHR10
- Sigma functions for WORD_W=64:
  - sigma0 = ROTR1 ^ ROTR8 ^ SHR7
  - sigma1 = ROTR19 ^ ROTR61 ^ SHR6
- Counter widths: k is 4 bits. t is 7 bits and wraps only via the return to IDLE; it never exceeds ROUNDS-1.
- NEXT is computed combinationally from registers only; there is no combinational path from D_IN or OUT_READY to D_OUT.

Optional Feature:
- Macro: MSG_SCHED_IDX_OUT_EN.
- When defined:
  - Adds output port T_IDX (7 bits), carrying the current round index t.
  - T_IDX is valid whenever OUT_VALID=1 and is 0 otherwise. Reset value is 0.
- When undefined:
  - The port is absent.
  - The round counter remains internal; behaviour is otherwise identical.

Test Plan:
- SHA-256 "abc" block (WORD_W=32, ROUNDS=64): load M0=0x61626380, M1..M14=0, M15=0x00000018 with OUT_READY=1. Required outputs: W16=0x61626380, W17=0x000F0000, W63=0x12B1EDEB. DONE pulses exactly once, on the cycle after W63 is accepted.
- Output backpressure: during RUN, toggle OUT_READY pseudo-randomly. D_OUT must hold stable while OUT_READY=0, and the sequence must match the first test exactly with no skipped or repeated words.
- Input gaps and input blocking: insert IN_VALID=0 cycles between message words; the schedule must be unchanged. Assert IN_VALID=1 throughout RUN; IN_READY must stay 0 and no word may be consumed until DONE.
- Reset mid-RUN: assert RST at t=30. Next cycle: OUT_VALID=0, IN_READY=1, D_OUT=0, no DONE. Reloading the "abc" block reproduces W63=0x12B1EDEB.
- SHA-512 (WORD_W=64, ROUNDS=80): load M0=0x0000000000000001, M1..M15=0. Required outputs: W16=0x0000000000000001, W17=0. Exactly 80 words are emitted, then DONE.
- Back-to-back blocks: present the next block's M0 in the cycle DONE is high. It must be accepted, and the second block's outputs must be independent of the first block.
